if_stage: RTL and testbench

Instruction-fetch stage with integrated IF/ID pipeline register. It owns the PC and fetches 32-bit RV32I instructions through a Wishbone B4 classic read master. It holds each fetched word in the IF/ID register and splits it into the raw opcode, register and immediate fields consumed by the decoder. It honours stall, flush and branch redirect from the downstream hazard/branch logic.

---
 rtl/if_stage.sv | 175 +++++++++++++++++
 tb/tb_if_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, fetches over a Wishbone B4 classic
// read master and holds the fetched word plus its decoded raw fields in IF/ID.
`timescale 1ns/1ps
module if_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic                  wb_ack_i,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_we_o,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [6:0]            opcode,
    output logic [4:0]            rd,
    output logic [2:0]            funct3,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [11:0]           I_imm,
    output logic [11:0]           S_imm,
    output logic [11:0]           SB_imm,
    output logic [19:0]           U_imm,
    output logic [19:0]           UJ_imm
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
    logic [DATA_WIDTH-1:0] id_inst_q, id_inst_d;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] target;
    logic                  load;
    logic [ADDR_WIDTH-1:0] load_pc;
    logic [DATA_WIDTH-1:0] load_inst;

    assign redirect = flush_i | branch_taken_i;
    assign target   = branch_target_i & ~ADDR_WIDTH'(3);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        pc_d        = pc_q;
        adr_d       = adr_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        load        = 1'b0;
        load_pc     = adr_q;
        load_inst   = wb_dat_i;

        case (state_q)
            S_FETCH: begin
                if (!req_q) begin
                    // Idle cycle between requests: launch, applying any redirect first.
                    req_d = 1'b1;
                    if (branch_taken_i) pc_d = target;
                end else if (redirect) begin
                    if (branch_taken_i) pc_d = target;
                    if (wb_ack_i) req_d   = 1'b0;
                    else          state_d = S_DRAIN;
                end else if (wb_ack_i) begin
                    req_d = 1'b0;
                    pc_d  = pc_q + ADDR_WIDTH'(4);
                    if (stall_i) begin
                        state_d     = S_HOLD;
                        skid_pc_d   = adr_q;
                        skid_inst_d = wb_dat_i;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    if (branch_taken_i) pc_d = target;
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                end else if (!stall_i) begin
                    load      = 1'b1;
                    load_pc   = skid_pc_q;
                    load_inst = skid_inst_q;
                    state_d   = S_FETCH;
                    req_d     = 1'b1;
                end
            end
            S_DRAIN: begin
                if (branch_taken_i) pc_d = target;
                if (wb_ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
                req_d   = 1'b0;
            end
        endcase

        // Bus address is captured only when a request starts, so it is stable while cyc is high.
        if (req_d && !req_q) adr_d = pc_d;

        if (flush_i)      valid_d = 1'b0;
        else if (load)    valid_d = 1'b1;
        else if (stall_i) valid_d = valid_q;
        else              valid_d = 1'b0;

        id_pc_d   = load ? load_pc   : id_pc_q;
        id_inst_d = load ? load_inst : id_inst_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            req_q       <= 1'b0;
            pc_q        <= PC_ADDR;
            adr_q       <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            valid_q     <= 1'b0;
            id_pc_q     <= '0;
            id_inst_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            pc_q        <= pc_d;
            adr_q       <= adr_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            valid_q     <= valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
        end
    end

    assign wb_cyc_o = req_q;
    assign wb_stb_o = req_q;
    assign wb_adr_o = req_q ? adr_q : '0;
    assign wb_sel_o = 4'b1111;
    assign wb_we_o  = 1'b0;

    assign valid_o = valid_q;
    assign pc_o    = id_pc_q;
    assign inst_o  = id_inst_q;

    // Raw slices only; sign extension is the decoder's job.
    assign opcode = id_inst_q[6:0];
    assign rd     = id_inst_q[11:7];
    assign funct3 = id_inst_q[14:12];
    assign rs1    = id_inst_q[19:15];
    assign rs2    = id_inst_q[24:20];
    assign I_imm  = id_inst_q[31:20];
    assign S_imm  = {id_inst_q[31:25], id_inst_q[11:7]};
    assign SB_imm = {id_inst_q[31], id_inst_q[7], id_inst_q[30:25], id_inst_q[11:8]};
    assign U_imm  = id_inst_q[31:12];
    assign UJ_imm = {id_inst_q[31], id_inst_q[19:12], id_inst_q[20], id_inst_q[30:21]};

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random stall/flush/branch traffic,
// every cycle compared against a transaction-level fetch model.
`timescale 1ns/1ps
module tb_if_stage;

    localparam logic [31:0] PC0 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_cyc_o, wb_stb_o, wb_ack_i, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        stall_i, flush_i, branch_taken_i;
    logic [31:0] branch_target_i;
    logic        valid_o;
    logic [31:0] pc_o, inst_o;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [11:0] I_imm, S_imm, SB_imm;
    logic [19:0] U_imm, UJ_imm;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .reset(reset),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .stall_i(stall_i), .flush_i(flush_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i),
        .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .I_imm(I_imm), .S_imm(S_imm), .SB_imm(SB_imm), .U_imm(U_imm), .UJ_imm(UJ_imm)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bus request in flight, whether its data is doomed,
    // a parked (stalled) word, and the IF/ID contents.
    bit          m_req, m_kill, m_skid, m_valid;
    logic [31:0] m_pc, m_adr, m_skid_pc, m_skid_w, m_opc, m_ow;

    int          ws    = 0;
    int          s_cnt = 0;
    bit          fixed_en = 1'b1;
    logic [31:0] fixed_w  = 32'h0000_0013;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return fixed_en ? fixed_w : ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_kill = 0; m_skid = 0; m_valid = 0;
        m_pc = PC0; m_adr = '0; m_skid_pc = '0; m_skid_w = '0; m_opc = '0; m_ow = '0;
    endtask

    task automatic check_ifid();
        logic [31:0] w;
        w = m_ow;
        chk("valid", 32'(valid_o), 32'(m_valid));
        if (m_valid) begin
            chk("pc_o",   pc_o,   m_opc);
            chk("inst_o", inst_o, w);
            chk("opcode", 32'(opcode), w & 32'h7F);
            chk("rd",     32'(rd),     (w >> 7) & 32'h1F);
            chk("funct3", 32'(funct3), (w >> 12) & 32'h7);
            chk("rs1",    32'(rs1),    (w >> 15) & 32'h1F);
            chk("rs2",    32'(rs2),    (w >> 20) & 32'h1F);
            chk("I_imm",  32'(I_imm),  w >> 20);
            chk("S_imm",  32'(S_imm),  (((w >> 25) & 32'h7F) << 5) | ((w >> 7) & 32'h1F));
            chk("SB_imm", 32'(SB_imm), (((w >> 31) & 1) << 11) | (((w >> 7) & 1) << 10)
                                     | (((w >> 25) & 32'h3F) << 4) | ((w >> 8) & 32'hF));
            chk("U_imm",  32'(U_imm),  w >> 12);
            chk("UJ_imm", 32'(UJ_imm), (((w >> 31) & 1) << 19) | (((w >> 12) & 32'hFF) << 11)
                                     | (((w >> 20) & 1) << 10) | ((w >> 21) & 32'h3FF));
        end
    endtask

    // One clock: check bus outputs, answer as the slave, drive controls,
    // advance the model, then check IF/ID after the edge.
    task automatic step(input bit st, input bit fl, input bit br, input logic [31:0] tg);
        logic        ack;
        logic [31:0] dat, t, wpc, ww;
        bit          was_req, word;
        chk("cyc", 32'(wb_cyc_o), 32'(m_req));
        chk("stb", 32'(wb_stb_o), 32'(m_req));
        if (m_req) chk("adr", wb_adr_o, m_adr);

        if (!wb_cyc_o)        begin ack = 1'b0; s_cnt = 0; end
        else if (s_cnt >= ws) begin ack = 1'b1; s_cnt = 0; end
        else                  begin ack = 1'b0; s_cnt++;   end
        dat = ack ? mem_word(wb_adr_o) : $urandom();

        stall_i = st; flush_i = fl; branch_taken_i = br; branch_target_i = tg;
        wb_ack_i = ack; wb_dat_i = dat;

        t = tg & 32'hFFFF_FFFC;
        was_req = m_req; word = 0; wpc = '0; ww = '0;
        if (m_skid) begin
            if (fl || br) begin
                m_skid = 0; m_req = 1;
                if (br) m_pc = t;
            end else if (!st) begin
                word = 1; wpc = m_skid_pc; ww = m_skid_w; m_skid = 0; m_req = 1;
            end
        end else if (!m_req) begin
            if (br) m_pc = t;
            m_req = 1;
        end else if (m_kill) begin
            if (br) m_pc = t;
            if (ack) begin m_kill = 0; m_req = 0; end
        end else if (fl || br) begin
            if (br) m_pc = t;
            if (ack) m_req = 0; else m_kill = 1;
        end else if (ack) begin
            m_req = 0;
            if (st) begin m_skid = 1; m_skid_pc = m_adr; m_skid_w = dat; end
            else    begin word = 1;   wpc = m_adr;       ww = dat;       end
            m_pc = m_pc + 4;
        end
        if (!was_req && m_req) m_adr = m_pc;

        if (fl)        m_valid = 0;
        else if (word) begin m_valid = 1; m_opc = wpc; m_ow = ww; end
        else if (!st)  m_valid = 0;

        @(posedge clk);
        @(negedge clk);
        check_ifid();
    endtask

    initial begin
        reset = 1'b0;
        stall_i = 0; flush_i = 0; branch_taken_i = 0; branch_target_i = '0;
        wb_ack_i = 0; wb_dat_i = '0;
        model_reset();
        repeat (3) @(negedge clk);

        chk("rst_cyc",   32'(wb_cyc_o), 32'd0);
        chk("rst_stb",   32'(wb_stb_o), 32'd0);
        chk("rst_adr",   wb_adr_o,      32'd0);
        chk("rst_valid", 32'(valid_o),  32'd0);
        chk("rst_pc",    pc_o,          32'd0);
        chk("rst_inst",  inst_o,        32'd0);
        chk("rst_sel",   32'(wb_sel_o), 32'hF);
        chk("rst_we",    32'(wb_we_o),  32'd0);
        chk("rst_uimm",  32'(U_imm),    32'd0);

        // Zero-wait slave streaming addi x0,x0,0.
        reset = 1'b1;
        repeat (6) step(0, 0, 0, '0);
        chk("t1_valid", 32'(valid_o), 32'd1);
        chk("t1_pc",    pc_o,   32'h8000_0008);
        chk("t1_inst",  inst_o, 32'h0000_0013);

        // Three wait states, addi sp,sp,-32.
        fixed_w = 32'hFE01_0113; ws = 3;
        for (int i = 0; i < 20 && !(m_valid && m_ow == 32'hFE01_0113); i++) step(0, 0, 0, '0);
        chk("t2_pc",     pc_o,        32'h8000_000C);
        chk("t2_opcode", 32'(opcode), 32'h13);
        chk("t2_rd",     32'(rd),     32'd2);
        chk("t2_funct3", 32'(funct3), 32'd0);
        chk("t2_rs1",    32'(rs1),    32'd2);
        chk("t2_rs2",    32'(rs2),    32'd0);
        chk("t2_iimm",   32'(I_imm),  32'hFE0);

        // Five stalled cycles straddling an ack.
        fixed_en = 0; ws = 1;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, '0);
            chk("t3_hold_pc",    pc_o,         32'h8000_000C);
            chk("t3_hold_valid", 32'(valid_o), 32'd1);
        end
        step(0, 0, 0, '0);
        chk("t3_new_valid", 32'(valid_o), 32'd1);
        chk("t3_new_pc",    pc_o,         32'h8000_0010);
        chk("t3_new_inst",  inst_o,       mem_word(32'h8000_0010));
        step(0, 0, 0, '0);
        chk("t3_bubble", 32'(valid_o), 32'd0);

        // Branch while a fetch is waiting on a slow slave.
        ws = 3;
        for (int i = 0; i < 20 && !m_req; i++) step(0, 0, 0, '0);
        step(0, 0, 1, 32'h8000_0103);
        for (int i = 0; i < 20 && !(m_req && !m_kill); i++) begin
            step(0, 0, 0, '0);
            chk("t4_no_valid", 32'(valid_o), 32'd0);
        end
        chk("t4_adr", wb_adr_o, 32'h8000_0100);
        for (int i = 0; i < 20 && !m_valid; i++) step(0, 0, 0, '0);
        chk("t4_pc", pc_o, 32'h8000_0100);

        // Flush while a stalled word is parked.
        ws = 0;
        for (int i = 0; i < 20 && !m_skid; i++) step(1, 0, 0, '0);
        step(1, 1, 0, '0);
        chk("t5_valid", 32'(valid_o), 32'd0);
        chk("t5_cyc",   32'(wb_cyc_o), 32'd1);
        chk("t5_adr",   wb_adr_o,      32'h8000_0108);
        for (int i = 0; i < 20 && !m_valid; i++) step(0, 0, 0, '0);
        chk("t5_pc", pc_o, 32'h8000_0108);

        // PC wraps past the top of the address space; target low bits ignored.
        step(0, 0, 1, 32'hFFFF_FFFE);
        for (int i = 0; i < 20 && !(m_valid && m_opc == 32'hFFFF_FFFC); i++) step(0, 0, 0, '0);
        chk("t6_pc", pc_o, 32'hFFFF_FFFC);
        for (int i = 0; i < 20 && !m_req; i++) step(0, 0, 0, '0);
        chk("t6_wrap_adr", wb_adr_o, 32'h0000_0000);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (!wb_cyc_o) ws = $urandom_range(0, 3);
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0, $urandom());
        end

        // Reset mid-cycle with a late ack.
        ws = 6;
        for (int i = 0; i < 30 && !m_req; i++) step(0, 0, 0, '0);
        #2 reset = 1'b0;
        #1;
        chk("t8_cyc_async",   32'(wb_cyc_o), 32'd0);
        chk("t8_valid_async", 32'(valid_o),  32'd0);
        chk("t8_pc_async",    pc_o,          32'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hBAD0_0BAD;
        @(posedge clk); @(negedge clk);
        chk("t8_cyc_in_rst", 32'(wb_cyc_o), 32'd0);
        reset = 1'b1;
        model_reset();
        @(posedge clk); @(negedge clk);
        chk("t8_cyc_restart", 32'(wb_cyc_o), 32'd1);
        chk("t8_adr_restart", wb_adr_o,      PC0);
        chk("t8_late_ack",    32'(valid_o),  32'd0);
        m_req = 1; m_adr = PC0; s_cnt = 0; ws = 0;
        for (int i = 0; i < 20 && !m_valid; i++) step(0, 0, 0, '0);
        chk("t8_pc",   pc_o,   PC0);
        chk("t8_inst", inst_o, mem_word(PC0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
